// File: rtl/boxcar_filter_mc.sv
// Time-multiplexed moving-average filter: one circular buffer, accumulator and
// fill counter per channel, window 2^k selectable at run time, 1-cycle latency.
module boxcar_filter_mc #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LOG2_MAX_LEN = 4,
    parameter int ROUNDING     = 1,
    localparam int CH_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int LEN_WIDTH   = $clog2(LOG2_MAX_LEN + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_ce,
    input  logic [CH_WIDTH-1:0]          i_channel,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic [LEN_WIDTH-1:0]         i_log2_len,
    output logic                         o_ce,
    output logic [CH_WIDTH-1:0]          o_channel,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_drop
);
    localparam int DEPTH  = 1 << LOG2_MAX_LEN;
    localparam int ACC_W  = DATA_WIDTH + LOG2_MAX_LEN + 1;
    localparam int FILL_W = LOG2_MAX_LEN + 1;

    // Buffer is read asynchronously so the read-modify-write closes in one cycle.
    logic signed [DATA_WIDTH-1:0] r_buf [NUM_CHANNELS][DEPTH];
    logic [LOG2_MAX_LEN-1:0]      r_wp   [NUM_CHANNELS];
    logic [FILL_W-1:0]            r_fill [NUM_CHANNELS];
    logic signed [ACC_W-1:0]      r_acc  [NUM_CHANNELS];
    logic [LEN_WIDTH-1:0]         r_k;

    logic                         r_o_ce;
    logic [CH_WIDTH-1:0]          r_o_channel;
    logic signed [DATA_WIDTH-1:0] r_o_data;
    logic                         r_o_drop;

    logic [LEN_WIDTH-1:0]         w_k_new;
    logic                         w_flush;
    logic                         w_ch_ok;
    logic                         w_accept;
    logic [CH_WIDTH-1:0]          w_ch_idx;
    logic [FILL_W-1:0]            w_len;
    logic [LOG2_MAX_LEN-1:0]      w_rd_ptr;
    logic [LOG2_MAX_LEN-1:0]      w_wp;
    logic signed [DATA_WIDTH-1:0] w_oldest;
    logic                         w_full;
    logic signed [ACC_W-1:0]      w_acc_next;
    logic [FILL_W-1:0]            w_fill_next;
    logic                         w_out_valid;
    logic signed [ACC_W-1:0]      w_rnd;
    logic signed [ACC_W-1:0]      w_sum;
    logic signed [DATA_WIDTH-1:0] w_avg;

    assign w_k_new  = (i_log2_len > LEN_WIDTH'(LOG2_MAX_LEN)) ? LEN_WIDTH'(LOG2_MAX_LEN) : i_log2_len;
    assign w_flush  = (w_k_new != r_k);
    assign w_ch_ok  = (int'(i_channel) < NUM_CHANNELS);
    assign w_accept = i_ce && w_ch_ok && !w_flush;
    assign w_ch_idx = w_ch_ok ? i_channel : '0;

    assign w_len    = FILL_W'(1) << r_k;
    assign w_wp     = r_wp[w_ch_idx];
    // Low bits of L are zero at the maximum window, so the oldest slot is wp itself.
    assign w_rd_ptr = w_wp - w_len[LOG2_MAX_LEN-1:0];
    assign w_oldest = r_buf[w_ch_idx][w_rd_ptr];
    assign w_full   = (r_fill[w_ch_idx] == w_len);

    assign w_acc_next  = r_acc[w_ch_idx] + ACC_W'(i_data) - (w_full ? ACC_W'(w_oldest) : '0);
    assign w_fill_next = w_full ? w_len : r_fill[w_ch_idx] + FILL_W'(1);
    assign w_out_valid = (w_fill_next == w_len);

    assign w_rnd = (ROUNDING != 0 && r_k != '0) ? (ACC_W'(1) << (r_k - LEN_WIDTH'(1))) : '0;
    assign w_sum = w_acc_next + w_rnd;
    assign w_avg = DATA_WIDTH'(w_sum >>> r_k);

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_accept) begin
            r_buf[w_ch_idx][w_wp] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_k         <= w_k_new;
            r_o_ce      <= 1'b0;
            r_o_channel <= '0;
            r_o_data    <= '0;
            r_o_drop    <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wp[c]   <= '0;
                r_fill[c] <= '0;
                r_acc[c]  <= '0;
            end
        end else begin
            r_o_ce   <= 1'b0;
            r_o_drop <= i_ce && (w_flush || !w_ch_ok);
            if (w_flush) begin
                r_k <= w_k_new;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_wp[c]   <= '0;
                    r_fill[c] <= '0;
                    r_acc[c]  <= '0;
                end
            end else if (w_accept) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (c == int'(w_ch_idx)) begin
                        r_acc[c]  <= w_acc_next;
                        r_fill[c] <= w_fill_next;
                        r_wp[c]   <= r_wp[c] + LOG2_MAX_LEN'(1);
                    end
                end
                if (w_out_valid) begin
                    r_o_ce      <= 1'b1;
                    r_o_channel <= i_channel;
                    r_o_data    <= w_avg;
                end
            end
        end
    end

    assign o_ce      = r_o_ce;
    assign o_channel = r_o_channel;
    assign o_data    = r_o_data;
    assign o_drop    = r_o_drop;

endmodule

// File: tb/tb_boxcar_filter_mc.sv
// Scoreboard bench: two filters (rounding and flooring) share one input stream;
// a window-history reference model predicts outputs and drops for both.
module tb_boxcar_filter_mc;
    localparam int NCH = 3;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_ce = 1'b0;
    logic [1:0] i_channel = '0;
    logic signed [7:0] i_data = '0;
    logic [2:0] i_log2_len = '0;

    logic       o0_ce, o1_ce, o0_drop, o1_drop;
    logic [1:0] o0_channel, o1_channel;
    logic signed [7:0] o0_data, o1_data;

    always #5 clk = ~clk;

    boxcar_filter_mc #(.DATA_WIDTH(8), .NUM_CHANNELS(NCH), .LOG2_MAX_LEN(4), .ROUNDING(1)) dut_r (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_channel(i_channel), .i_data(i_data),
        .i_log2_len(i_log2_len), .o_ce(o0_ce), .o_channel(o0_channel), .o_data(o0_data), .o_drop(o0_drop));

    boxcar_filter_mc #(.DATA_WIDTH(8), .NUM_CHANNELS(NCH), .LOG2_MAX_LEN(4), .ROUNDING(0)) dut_f (
        .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_channel(i_channel), .i_data(i_data),
        .i_log2_len(i_log2_len), .o_ce(o1_ce), .o_channel(o1_channel), .o_data(o1_data), .o_drop(o1_drop));

    typedef struct {
        int cyc;
        int ch;
        int dr;
        int df;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   dq0[$];
    int   dq1[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    int hist [NCH][$];
    int kreg = 0;
    int cur_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clampk(input int v);
        return (v > 4) ? 4 : v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: keep the last L accepted samples per channel and average them.
    task automatic step(input bit ce, input int ch, input int d, input int len, input bit rst);
        int   stamp;
        int   lw;
        int   sum;
        exp_t e;
        @(negedge clk);
        i_ce       = ce;
        i_channel  = ch[1:0];
        i_data     = d[7:0];
        i_log2_len = len[2:0];
        i_reset    = rst;
        cur_len    = len;
        stamp      = cyc + 1;
        if (rst) begin
            for (int c = 0; c < NCH; c++) hist[c].delete();
            kreg = clampk(len);
        end else if (clampk(len) != kreg) begin
            for (int c = 0; c < NCH; c++) hist[c].delete();
            kreg = clampk(len);
            if (ce) begin
                dq0.push_back(stamp);
                dq1.push_back(stamp);
            end
        end else if (ce) begin
            if (ch >= NCH) begin
                dq0.push_back(stamp);
                dq1.push_back(stamp);
            end else begin
                lw = 1 << kreg;
                hist[ch].push_back(d);
                if (hist[ch].size() > lw) void'(hist[ch].pop_front());
                if (hist[ch].size() == lw) begin
                    sum = 0;
                    foreach (hist[ch][j]) sum += hist[ch][j];
                    e.cyc = stamp;
                    e.ch  = ch;
                    e.df  = sum >>> kreg;
                    e.dr  = (sum + ((kreg > 0) ? (1 << (kreg - 1)) : 0)) >>> kreg;
                    q0.push_back(e);
                    q1.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, cur_len, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (o0_ce === 1'b1) begin
                if (q0.size() == 0) begin
                    check("round_unexpected_out", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("round_latency", cyc, e.cyc);
                    check("round_channel", int'(o0_channel), e.ch);
                    check("round_data", int'(o0_data), e.dr);
                    $display("out round cyc=%0d ch=%0d data=%0d exp=%0d", cyc, o0_channel, o0_data, e.dr);
                end
            end
            if (o1_ce === 1'b1) begin
                if (q1.size() == 0) begin
                    check("floor_unexpected_out", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("floor_latency", cyc, e.cyc);
                    check("floor_channel", int'(o1_channel), e.ch);
                    check("floor_data", int'(o1_data), e.df);
                    $display("out floor cyc=%0d ch=%0d data=%0d exp=%0d", cyc, o1_channel, o1_data, e.df);
                end
            end
            if (o0_drop === 1'b1) begin
                if (dq0.size() == 0) check("round_unexpected_drop", 1, 0);
                else check("round_drop_cycle", cyc, dq0.pop_front());
                $display("drop round cyc=%0d", cyc);
            end
            if (o1_drop === 1'b1) begin
                if (dq1.size() == 0) check("floor_unexpected_drop", 1, 0);
                else check("floor_drop_cycle", cyc, dq1.pop_front());
            end
            if (o0_ce !== 1'b1 && o1_ce !== 1'b1 && o0_drop !== 1'b1 && o1_drop !== 1'b1) begin
                if (q0.size() > 0 && q0[0].cyc < cyc) check("round_missing_out", cyc, q0[0].cyc);
                if (q0.size() > 0 && q0[0].cyc < cyc) void'(q0.pop_front());
            end
        end
    end

    initial begin
        int len;
        // Reset and its output state.
        step(1'b0, 0, 0, 2, 1'b1);
        step(1'b0, 0, 0, 2, 1'b1);
        step(1'b0, 0, 0, 2, 1'b0);
        check("reset_o_ce", int'(o0_ce), 0);
        check("reset_o_drop", int'(o0_drop), 0);
        check("reset_o_data", int'(o0_data), 0);
        check("reset_o_channel", int'(o0_channel), 0);
        check("reset_floor_o_ce", int'(o1_ce), 0);
        mon_en = 1'b1;

        // k=2 ramp on channel 0.
        for (int i = 1; i <= 5; i++) step(1'b1, 0, 4 * i, 2, 1'b0);

        // k=3 interleaved constants on channels 0 and 1.
        idle(1);
        step(1'b0, 0, 0, 3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 0, 100, 3, 1'b0);
            step(1'b1, 1, -100, 3, 1'b0);
        end

        // k=1 rounding corner cases, flushing between pairs.
        step(1'b0, 0, 0, 1, 1'b0);
        step(1'b1, 2, 1, 1, 1'b0);
        step(1'b1, 2, 2, 1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 2, 7, 0, 1'b0);
        step(1'b1, 2, -5, 0, 1'b0);
        step(1'b0, 0, 0, 1, 1'b0);
        step(1'b1, 2, -1, 1, 1'b0);
        step(1'b1, 2, -2, 1, 1'b0);

        // k=4 extremes: 16 x 127 then 16 x -128.
        step(1'b0, 0, 0, 4, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 0, 127, 4, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 0, -128, 4, 1'b0);
        // Out-of-range select clamps to the same window: no flush.
        step(1'b1, 0, 50, 7, 1'b0);

        // Window change with a sample in the same cycle is dropped.
        step(1'b0, 0, 0, 2, 1'b0);
        step(1'b1, 1, 9, 2, 1'b0);
        step(1'b1, 1, 9, 2, 1'b0);
        step(1'b1, 1, 30, 1, 1'b0);
        step(1'b1, 1, 10, 1, 1'b0);
        step(1'b1, 1, 21, 1, 1'b0);

        // Reset mid-window, then invalid channel.
        step(1'b0, 0, 0, 2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2, 60, 2, 1'b0);
        step(1'b1, 2, 60, 2, 1'b1);
        step(1'b1, 2, 4, 2, 1'b0);
        idle(1);
        step(1'b1, 3, 99, 2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2, 8 + i, 2, 1'b0);
        step(1'b1, 3, -99, 2, 1'b0);
        step(1'b1, 2, 1, 2, 1'b0);

        // Randomised traffic.
        len = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) len = $urandom_range(0, 7);
            step($urandom_range(0, 4) != 0, $urandom_range(0, 3),
                 int'($urandom_range(0, 255)) - 128, len, $urandom_range(0, 299) == 0);
        end

        idle(3);
        check("round_queue_empty", q0.size(), 0);
        check("floor_queue_empty", q1.size(), 0);
        check("round_drops_empty", dq0.size(), 0);
        check("floor_drops_empty", dq1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
